// File: rtl/cursor_control.sv
// Button-driven cursor/view tracker plus read-modify-write cell toggle on the shared board RAM.
// Optional auto-repeat of held direction buttons is built only when AUTOREPEAT_EN is defined.

module cursor_axis #(
    parameter int W        = 8,
    parameter int VIEW_LOG = 6
`ifdef AUTOREPEAT_EN
    ,
    parameter logic [31:0] DELAY  = 32'd65_000_000,
    parameter logic [31:0] PERIOD = 32'd13_000_000
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] pos,
    output logic [W-1:0] view
);
    localparam int VIEW_SIZE = 1 << VIEW_LOG;

    logic         inc_q, dec_q, inc_edge, dec_edge, step_inc, step_dec;
    logic [W-1:0] next_pos, rel;

    assign inc_edge = inc & ~inc_q;
    assign dec_edge = dec & ~dec_q;

`ifdef AUTOREPEAT_EN
    logic [31:0] cnt;
    logic        phase, hold, rpt;

    // phase 0 waits out the initial delay, phase 1 paces the repeats
    assign hold     = inc ^ dec;
    assign rpt      = hold && !(inc_edge || dec_edge) && (cnt == (phase ? PERIOD : DELAY));
    assign step_inc = (inc_edge & ~dec_edge) | (rpt & inc);
    assign step_dec = (dec_edge & ~inc_edge) | (rpt & dec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!hold) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (inc_edge || dec_edge) begin
            cnt   <= 32'd1;
            phase <= 1'b0;
        end else if (rpt) begin
            cnt   <= 32'd1;
            phase <= 1'b1;
        end else begin
            cnt   <= cnt + 32'd1;
        end
    end
`else
    assign step_inc = inc_edge & ~dec_edge;
    assign step_dec = dec_edge & ~inc_edge;
`endif

    assign next_pos = step_inc ? pos + W'(1) : pos - W'(1);
    assign rel      = next_pos - view;

    // view moves with the step so the cursor never leaves the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            pos   <= '0;
            view  <= '0;
        end else begin
            inc_q <= inc;
            dec_q <= dec;
            if (step_inc || step_dec) begin
                pos <= next_pos;
                if (rel == W'(VIEW_SIZE))
                    view <= view + W'(1);
                else if (&rel)
                    view <= view - W'(1);
            end
        end
    end
endmodule

module cursor_control #(
    parameter int          LOG_BOARD_SIZE = 8,
    parameter int          LOG_VIEW_SIZE  = 6,
    parameter int          LOG_WORD_SIZE  = 4,
    parameter int          LOG_MAX_ADDR   = 12,
    parameter logic [31:0] REPEAT_DELAY   = 32'd65_000_000,
    parameter logic [31:0] REPEAT_PERIOD  = 32'd13_000_000
) (
    input  logic                            clk_130mhz,
    input  logic                            rst_in,
    input  logic                            btn_up_in,
    input  logic                            btn_down_in,
    input  logic                            btn_left_in,
    input  logic                            btn_right_in,
    input  logic                            btn_toggle_in,
    input  logic                            render_done_in,
    input  logic [(1<<LOG_WORD_SIZE)-1:0]   data_r_in,
    output logic [LOG_BOARD_SIZE-1:0]       cursor_x_out,
    output logic [LOG_BOARD_SIZE-1:0]       cursor_y_out,
    output logic [LOG_BOARD_SIZE-1:0]       view_x_out,
    output logic [LOG_BOARD_SIZE-1:0]       view_y_out,
    output logic [LOG_MAX_ADDR-1:0]         addr_out,
    output logic                            we_out,
    output logic [(1<<LOG_WORD_SIZE)-1:0]   data_w_out,
    output logic                            busy_out
);
    localparam int WORD_SIZE = 1 << LOG_WORD_SIZE;

    typedef enum logic [1:0] {IDLE, WAIT, READ, MODIFY} state_t;

    state_t                             state;
    logic [1:0]                         inc, dec;
    logic [1:0][LOG_BOARD_SIZE-1:0]     pos, view;
    logic                               toggle_q;
    logic [LOG_BOARD_SIZE-1:0]          tx, ty;
    logic [WORD_SIZE-1:0]               mask;

    // axis 0 is x (right/left), axis 1 is y (down/up)
    assign inc = {btn_down_in, btn_right_in};
    assign dec = {btn_up_in, btn_left_in};

    for (genvar a = 0; a < 2; a++) begin : g_axis
        cursor_axis #(
            .W        (LOG_BOARD_SIZE),
            .VIEW_LOG (LOG_VIEW_SIZE)
`ifdef AUTOREPEAT_EN
            ,
            .DELAY    (REPEAT_DELAY),
            .PERIOD   (REPEAT_PERIOD)
`endif
        ) u_axis (
            .clk  (clk_130mhz),
            .rst  (rst_in),
            .inc  (inc[a]),
            .dec  (dec[a]),
            .pos  (pos[a]),
            .view (view[a])
        );
    end

    assign cursor_x_out = pos[0];
    assign cursor_y_out = pos[1];
    assign view_x_out   = view[0];
    assign view_y_out   = view[1];

    // leftmost cell lives in the word MSB
    always_comb begin
        mask = '0;
        mask[~tx[LOG_WORD_SIZE-1:0]] = 1'b1;
    end

    // RAM data arrives during MODIFY, the only cycle we_out is high
    assign data_w_out = we_out ? (data_r_in ^ mask) : '0;

    always_ff @(posedge clk_130mhz or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            toggle_q <= 1'b0;
            tx       <= '0;
            ty       <= '0;
            addr_out <= '0;
            we_out   <= 1'b0;
            busy_out <= 1'b0;
        end else begin
            toggle_q <= btn_toggle_in;
            we_out   <= 1'b0;
            case (state)
                IDLE: if (btn_toggle_in && !toggle_q) begin
                    tx       <= pos[0];
                    ty       <= pos[1];
                    busy_out <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: if (render_done_in) begin
                    addr_out <= LOG_MAX_ADDR'({ty, tx[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]});
                    state    <= READ;
                end
                READ: if (render_done_in) begin
                    we_out <= 1'b1;
                    state  <= MODIFY;
                end else begin
                    state  <= WAIT;
                end
                MODIFY: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cursor_control.sv
// Directed bench for cursor_control: table of button pulses with expected cursor/view,
// then hand sequences for the toggle FSM, mid-operation reset and held-button behaviour.

module tb_cursor_control;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, toggle = 1'b0;
    logic        done = 1'b0;
    logic [15:0] data_r = 16'h0000;
    logic [7:0]  cx, cy, vx, vy;
    logic [11:0] addr;
    logic        we, busy;
    logic [15:0] data_w;

    int total = 0;
    int bad   = 0;

    int          wr_cnt;
    logic [11:0] w_addr;
    logic [15:0] w_data;
    logic        we_last;
    logic        busy_after;

    always #5 clk = ~clk;

    cursor_control #(
        .REPEAT_DELAY  (32'd10),
        .REPEAT_PERIOD (32'd4)
    ) dut (
        .clk_130mhz     (clk),
        .rst_in         (rst),
        .btn_up_in      (up),
        .btn_down_in    (down),
        .btn_left_in    (left),
        .btn_right_in   (right),
        .btn_toggle_in  (toggle),
        .render_done_in (done),
        .data_r_in      (data_r),
        .cursor_x_out   (cx),
        .cursor_y_out   (cy),
        .view_x_out     (vx),
        .view_y_out     (vy),
        .addr_out       (addr),
        .we_out         (we),
        .data_w_out     (data_w),
        .busy_out       (busy)
    );

    typedef struct {
        logic [3:0] dirs;   // {up, down, left, right}
        int         reps;
        logic [7:0] cx, cy, vx, vy;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] dirs);
        @(negedge clk);
        {up, down, left, right} = dirs;
        @(negedge clk);
        {up, down, left, right} = 4'b0000;
    endtask

    task automatic tick();
        @(negedge clk);
        if (we_last) busy_after = busy;
        we_last = we;
        if (we) begin
            wr_cnt++;
            w_addr = addr;
            w_data = data_w;
        end
    endtask

    task automatic watch_reset();
        wr_cnt     = 0;
        w_addr     = '0;
        w_data     = '0;
        we_last    = 1'b0;
        busy_after = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 3,  8'd3,   8'd0,   8'd0,   8'd0};
        vecs[1]  = '{4'b0010, 4,  8'd255, 8'd0,   8'd255, 8'd0};
        vecs[2]  = '{4'b0001, 1,  8'd0,   8'd0,   8'd255, 8'd0};
        vecs[3]  = '{4'b0100, 64, 8'd0,   8'd64,  8'd255, 8'd1};
        vecs[4]  = '{4'b1000, 1,  8'd0,   8'd63,  8'd255, 8'd1};
        vecs[5]  = '{4'b1000, 63, 8'd0,   8'd0,   8'd255, 8'd0};
        vecs[6]  = '{4'b0101, 1,  8'd1,   8'd1,   8'd255, 8'd0};
        vecs[7]  = '{4'b0011, 1,  8'd1,   8'd1,   8'd255, 8'd0};
        vecs[8]  = '{4'b1100, 1,  8'd1,   8'd1,   8'd255, 8'd0};
        vecs[9]  = '{4'b1010, 1,  8'd0,   8'd0,   8'd255, 8'd0};
        vecs[10] = '{4'b1000, 1,  8'd0,   8'd255, 8'd255, 8'd255};
        vecs[11] = '{4'b0100, 1,  8'd0,   8'd0,   8'd255, 8'd255};
        vecs[12] = '{4'b0001, 18, 8'd18,  8'd0,   8'd255, 8'd255};
        vecs[13] = '{4'b0100, 2,  8'd18,  8'd2,   8'd255, 8'd255};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cx", cx, 0);
        chk("rst_cy", cy, 0);
        chk("rst_vx", vx, 0);
        chk("rst_vy", vy, 0);
        chk("rst_addr", addr, 0);
        chk("rst_we", we, 0);
        chk("rst_dw", data_w, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) pulse(vecs[i].dirs);
            chk($sformatf("v%0d_cx", i), cx, vecs[i].cx);
            chk($sformatf("v%0d_cy", i), cy, vecs[i].cy);
            chk($sformatf("v%0d_vx", i), vx, vecs[i].vx);
            chk($sformatf("v%0d_vy", i), vy, vecs[i].vy);
        end

        // toggle at (18,2) with RAM free
        watch_reset();
        done = 1'b1;
        data_r = 16'h0000;
        toggle = 1'b1;
        tick();
        toggle = 1'b0;
        chk("a_busy_set", busy, 1);
        repeat (8) tick();
        chk("a_writes", wr_cnt, 1);
        chk("a_addr", w_addr, 12'h021);
        chk("a_data", w_data, 16'h2000);
        chk("a_busy_drop", busy_after, 0);

        // renderer busy, then done drops during READ
        watch_reset();
        done = 1'b0;
        data_r = 16'hFFFF;
        toggle = 1'b1;
        tick();
        toggle = 1'b0;
        repeat (6) tick();
        chk("b_no_write", wr_cnt, 0);
        chk("b_busy", busy, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (3) tick();
        chk("b_read_abort", wr_cnt, 0);
        done = 1'b1;
        repeat (8) tick();
        chk("b_writes", wr_cnt, 1);
        chk("b_addr", w_addr, 12'h021);
        chk("b_data", w_data, 16'hDFFF);
        chk("b_busy_drop", busy_after, 0);

        // cursor moves and a second toggle while the first waits
        watch_reset();
        done = 1'b0;
        data_r = 16'h0001;
        toggle = 1'b1;
        tick();
        toggle = 1'b0;
        repeat (5) pulse(4'b0001);
        pulse(4'b0100);
        @(negedge clk);
        toggle = 1'b1;
        @(negedge clk);
        toggle = 1'b0;
        chk("c_cx", cx, 23);
        chk("c_cy", cy, 3);
        done = 1'b1;
        repeat (12) tick();
        chk("c_writes", wr_cnt, 1);
        chk("c_addr", w_addr, 12'h021);
        chk("c_data", w_data, 16'h2001);

        // reset during the write cycle
        watch_reset();
        data_r = 16'h0000;
        toggle = 1'b1;
        tick();
        toggle = 1'b0;
        tick();
        tick();
        chk("r_we_before", we, 1);
        rst = 1'b1;
        #1;
        chk("r_we", we, 0);
        chk("r_busy", busy, 0);
        chk("r_addr", addr, 0);
        chk("r_cx", cx, 0);
        chk("r_dw", data_w, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done = 1'b0;

        // held right for 22 cycles
        @(negedge clk);
        right = 1'b1;
        repeat (22) @(negedge clk);
        right = 1'b0;
        @(negedge clk);
`ifdef AUTOREPEAT_EN
        chk("hold_cx", cx, 4);
`else
        chk("hold_cx", cx, 1);
`endif
        chk("hold_vx", vx, 0);
        chk("hold_cy", cy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
